// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, receiver state encoding and a
// byte-lane packing helper used by the serial word receiver and transmitter.
package uart_pkg;

   localparam int DATA_BITS  = 8;
   localparam int STOP_BITS  = 1;
   localparam int WORD_BYTES = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_STOP    = 3'd3,
      ST_CLEANUP = 3'd4
   } rx_state_e;

   // Places a byte into a word MSB-first: lane 0 is bits [31:24], lane 3 is [7:0].
   function automatic logic [31:0] pack_byte(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  data);
      logic [31:0] result;
      result = word;
      case (lane)
         2'd0:    result[31:24] = data;
         2'd1:    result[23:16] = data;
         2'd2:    result[15:8]  = data;
         default: result[7:0]   = data;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: synchronizes the line, samples mid-bit and presents
// each accepted byte (or a framing error) as a one-cycle registered strobe.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 20
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       i_serial,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   output logic       o_frame_err,
   output logic       o_accept,
   output logic       o_reject,
   output logic [7:0] o_data
);

   localparam int              CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]   HALF = CW'(CLKS_PER_BIT / 2);

   rx_state_e     state_q, state_d;
   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    byte_q, byte_d;
   logic          byte_valid_q, byte_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          rx;
   logic          accept;
   logic          reject;

   assign rx = sync_q[1];

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync_q       <= 2'b11;
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         byte_q       <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         byte_q       <= byte_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   always_comb begin
      sync_d   = {sync_q[0], i_serial};
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      byte_d   = byte_q;
      accept   = 1'b0;
      reject   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (!rx) state_d = ST_START;
         end
         // A line that has gone high again by mid start bit was a glitch.
         ST_START: begin
            if (cnt_q == HALF) begin
               cnt_d   = '0;
               state_d = rx ? ST_IDLE : ST_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               shift_d = {rx, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_STOP: begin
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = ST_CLEANUP;
               if (rx) begin
                  accept = 1'b1;
                  byte_d = shift_q;
               end else begin
                  reject = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_CLEANUP: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      byte_valid_d = accept;
      frame_err_d  = reject;
   end

   // o_accept/o_reject fire on the stop-bit sample edge so the word logic can
   // register its result alongside the byte strobes.
   assign o_byte       = byte_q;
   assign o_byte_valid = byte_valid_q;
   assign o_frame_err  = frame_err_q;
   assign o_accept     = accept;
   assign o_reject     = reject;
   assign o_data       = shift_q;

endmodule

// File: rtl/serial_to_word_rx.sv
// UART receiver that reports every byte and, in word mode, packs four bytes
// MSB-first into a 32-bit word. Outputs are valid-only strobes with no ready.
module serial_to_word_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 20
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        i_serial,
   input  logic        i_mode_select,
   output logic [7:0]  o_byte,
   output logic        o_byte_valid,
   output logic [31:0] o_word,
   output logic        o_word_valid,
   output logic        o_frame_err
);

   logic        rx_accept;
   logic        rx_reject;
   logic [7:0]  rx_data;

   logic        mode_q, mode_d;
   logic [1:0]  idx_q, idx_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] word_q, word_d;
   logic        word_valid_q, word_valid_d;
   logic        mode_change;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clock        (clock),
      .reset_n      (reset_n),
      .i_serial     (i_serial),
      .o_byte       (o_byte),
      .o_byte_valid (o_byte_valid),
      .o_frame_err  (o_frame_err),
      .o_accept     (rx_accept),
      .o_reject     (rx_reject),
      .o_data       (rx_data)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         mode_q       <= 1'b0;
         idx_q        <= '0;
         buf_q        <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
      end else begin
         mode_q       <= mode_d;
         idx_q        <= idx_d;
         buf_q        <= buf_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
      end
   end

   assign mode_change = (i_mode_select != mode_q);

   always_comb begin
      mode_d       = i_mode_select;
      idx_d        = idx_q;
      buf_d        = buf_q;
      word_d       = word_q;
      word_valid_d = 1'b0;

      // The registered mode governs the byte being accepted, so a byte that
      // lands with a mode edge is counted under the old mode.
      if (rx_accept && mode_q) begin
         buf_d = pack_byte(buf_q, idx_q, rx_data);
         if (idx_q == 2'(WORD_BYTES - 1)) begin
            word_d       = buf_d;
            word_valid_d = 1'b1;
            idx_d        = '0;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end

      if (rx_reject)   idx_d = '0;
      if (mode_change) idx_d = '0;
   end

   assign o_word       = word_q;
   assign o_word_valid = word_valid_q;

endmodule

// File: tb/tb_serial_to_word_rx.sv
// Directed bench for serial_to_word_rx: drives 8N1 frames and compares every
// byte/word strobe against hand-computed expected values.
module tb_serial_to_word_rx;
   import uart_pkg::*;

   localparam int CLKS = 20;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        i_serial = 1'b1;
   logic        i_mode_select = 1'b0;
   logic [7:0]  o_byte;
   logic        o_byte_valid;
   logic [31:0] o_word;
   logic        o_word_valid;
   logic        o_frame_err;

   int n_checks = 0;
   int n_pass   = 0;
   int n_byte_seen = 0;
   int n_word_seen = 0;
   int n_ferr_seen = 0;
   int b0, w0, f0;

   logic [7:0]  exp_byte_q[$];
   logic [31:0] exp_word_q[$];

   serial_to_word_rx #(
      .CLKS_PER_BIT (CLKS)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .i_serial      (i_serial),
      .i_mode_select (i_mode_select),
      .o_byte        (o_byte),
      .o_byte_valid  (o_byte_valid),
      .o_word        (o_word),
      .o_word_valid  (o_word_valid),
      .o_frame_err   (o_frame_err)
   );

   // clock / reset block
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // driver tasks
   task automatic idle(input int n);
      i_serial = 1'b1;
      repeat (n) @(negedge clock);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clock);
      i_serial = 1'b0;
      repeat (CLKS) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         i_serial = b[i];
         repeat (CLKS) @(negedge clock);
      end
      i_serial = stop_bit;
      repeat (CLKS) @(negedge clock);
      i_serial = 1'b1;
   endtask

   task automatic send_byte_exp(input logic [7:0] b);
      exp_byte_q.push_back(b);
      send_byte(b, 1'b1);
   endtask

   task automatic send_word(input logic [31:0] w);
      exp_word_q.push_back(w);
      for (int i = 0; i < 4; i++) send_byte_exp(w[31-8*i -: 8]);
   endtask

   // scoreboard
   always @(negedge clock) begin
      if (o_byte_valid) begin
         n_byte_seen++;
         check("byte_expected", exp_byte_q.size() != 0, 1'b1);
         if (exp_byte_q.size() != 0) check("byte_value", o_byte, exp_byte_q.pop_front());
      end
      if (o_word_valid) begin
         n_word_seen++;
         check("word_with_byte", o_byte_valid, 1'b1);
         check("word_expected", exp_word_q.size() != 0, 1'b1);
         if (exp_word_q.size() != 0) check("word_value", o_word, exp_word_q.pop_front());
      end
      if (o_frame_err) begin
         n_ferr_seen++;
         check("ferr_no_byte", o_byte_valid, 1'b0);
      end
   end

   initial begin
      // reset state
      reset_n = 1'b0;
      repeat (5) @(negedge clock);
      check("rst_byte", o_byte, 8'h00);
      check("rst_word", o_word, 32'h0);
      check("rst_byte_valid", o_byte_valid, 1'b0);
      check("rst_word_valid", o_word_valid, 1'b0);
      check("rst_frame_err", o_frame_err, 1'b0);
      check("rst_state", dut.u_rx.state_q, ST_IDLE);
      reset_n = 1'b1;
      idle(10);

      // byte mode
      b0 = n_byte_seen; w0 = n_word_seen;
      send_byte_exp(8'hAB);
      send_byte_exp(8'h10);
      idle(20);
      check("bm_bytes", n_byte_seen - b0, 2);
      check("bm_words", n_word_seen - w0, 0);
      check("bm_last_byte", o_byte, 8'h10);
      check("bm_word_hold", o_word, 32'h0);

      // word mode
      i_mode_select = 1'b1;
      idle(5);
      b0 = n_byte_seen; w0 = n_word_seen;
      send_word(32'h00FF12CD);
      idle(20);
      check("wm_bytes", n_byte_seen - b0, 4);
      check("wm_words", n_word_seen - w0, 1);
      check("wm_word", o_word, 32'h00FF12CD);

      // frame error drops the partial word
      b0 = n_byte_seen; w0 = n_word_seen; f0 = n_ferr_seen;
      send_byte_exp(8'hDE);
      send_byte(8'hAD, 1'b0);
      idle(40);
      check("fe_count", n_ferr_seen - f0, 1);
      check("fe_byte_hold", o_byte, 8'hDE);
      check("fe_word_hold", o_word, 32'h00FF12CD);
      send_word(32'h01020304);
      idle(20);
      check("fe_bytes", n_byte_seen - b0, 5);
      check("fe_words", n_word_seen - w0, 1);
      check("fe_word", o_word, 32'h01020304);
      check("fe_total_errs", n_ferr_seen - f0, 1);

      // 5-cycle low glitch
      b0 = n_byte_seen; w0 = n_word_seen; f0 = n_ferr_seen;
      @(negedge clock);
      i_serial = 1'b0;
      repeat (5) @(negedge clock);
      i_serial = 1'b1;
      check("gl_entered_start", dut.u_rx.state_q, ST_START);
      idle(40);
      check("gl_back_idle", dut.u_rx.state_q, ST_IDLE);
      check("gl_bytes", n_byte_seen - b0, 0);
      check("gl_words", n_word_seen - w0, 0);
      check("gl_errs", n_ferr_seen - f0, 0);

      // mode toggle clears the byte index
      b0 = n_byte_seen; w0 = n_word_seen;
      send_byte_exp(8'h11);
      send_byte_exp(8'h22);
      idle(5);
      i_mode_select = 1'b0;
      idle(5);
      i_mode_select = 1'b1;
      idle(5);
      send_word(32'h33445566);
      idle(20);
      check("mt_bytes", n_byte_seen - b0, 6);
      check("mt_words", n_word_seen - w0, 1);
      check("mt_word", o_word, 32'h33445566);

      // reset during DATA
      i_mode_select = 1'b0;
      idle(5);
      b0 = n_byte_seen; w0 = n_word_seen; f0 = n_ferr_seen;
      i_serial = 1'b0;
      repeat (CLKS) @(negedge clock);
      for (int i = 0; i < 3; i++) begin
         i_serial = 1'b0;
         repeat (CLKS) @(negedge clock);
      end
      check("rd_in_data", dut.u_rx.state_q, ST_DATA);
      reset_n  = 1'b0;
      i_serial = 1'b1;
      repeat (4) @(negedge clock);
      check("rd_byte", o_byte, 8'h00);
      check("rd_word", o_word, 32'h0);
      check("rd_state", dut.u_rx.state_q, ST_IDLE);
      reset_n = 1'b1;
      idle(20);
      check("rd_no_pulses", (n_byte_seen - b0) + (n_word_seen - w0) + (n_ferr_seen - f0), 0);
      send_byte_exp(8'h5A);
      idle(20);
      check("rd_next_byte", o_byte, 8'h5A);
      check("rd_next_count", n_byte_seen - b0, 1);

      // final report
      check("byte_q_drained", exp_byte_q.size(), 0);
      check("word_q_drained", exp_word_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
